// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - pipelined barrel shifter with valid/ready handshake
// Mux levels are grouped StagesPerReg per register stage; each stage carries its beat's control fields.
module pipelined_shifter #(
  parameter int BitWidth     = 32,
  parameter int StagesPerReg = 1
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        InValid,
  output logic                        InReady,
  input  logic                        En,
  input  logic                        Left,
  input  logic                        RotateEnable,
  input  logic                        Arith,
  input  logic [BitWidth-1:0]         dIN,
  input  logic [$clog2(BitWidth)-1:0] ShAmount,
  output logic                        OutValid,
  input  logic                        OutReady,
  output logic [BitWidth-1:0]         dOUT,
  output logic                        Busy
);

  localparam int ShiftWidth = $clog2(BitWidth);
  localparam int PipeDepth  = (ShiftWidth + StagesPerReg - 1) / StagesPerReg;

  logic [PipeDepth-1:0]                 vReg, enReg, leftReg, rotReg, arithReg, signReg;
  logic [PipeDepth-1:0][BitWidth-1:0]   dataReg;
  logic [PipeDepth-1:0][ShiftWidth-1:0] amtReg;
  logic [PipeDepth-1:0][BitWidth-1:0]   nxtData;
  logic [PipeDepth-1:0]                 ld;

  // Index 0 is the input port; index k+1 is the output of register stage k.
  logic [PipeDepth:0]                 stValid, stEn, stLeft, stRot, stArith, stSign;
  logic [PipeDepth:0][BitWidth-1:0]   stData;
  logic [PipeDepth:0][ShiftWidth-1:0] stAmt;
  logic                               unusedTail;

  assign stValid = {vReg, InValid};
  assign stEn    = {enReg, En};
  assign stLeft  = {leftReg, Left};
  assign stRot   = {rotReg, RotateEnable};
  assign stArith = {arithReg, Arith};
  assign stSign  = {signReg, dIN[BitWidth-1]};
  assign stData  = {dataReg, dIN};
  assign stAmt   = {amtReg, ShAmount};

  assign unusedTail = ^{stEn[PipeDepth], stLeft[PipeDepth], stRot[PipeDepth],
                        stArith[PipeDepth], stSign[PipeDepth], stAmt[PipeDepth]};

  function automatic logic [BitWidth-1:0] shiftLevel(
    input logic [BitWidth-1:0] x,
    input int                  lvl,
    input logic                left,
    input logic                rot,
    input logic                arith,
    input logic                sign
  );
    int d;
    d = 1 << lvl;
    if (rot) begin
      if (left) return (x << d) | (x >> (BitWidth - d));
      return (x >> d) | (x << (BitWidth - d));
    end
    if (left) return x << d;
    if (arith && sign) return (x >> d) | ~({BitWidth{1'b1}} >> d);
    return x >> d;
  endfunction

  // Stall chain: a stage loads if it is empty or everything downstream of it moves.
  always_comb begin
    logic acc;
    ld  = '0;
    acc = OutReady;
    for (int k = PipeDepth - 1; k >= 0; k--) begin
      acc   = acc || !vReg[k];
      ld[k] = acc;
    end
  end

  always_comb begin
    logic [BitWidth-1:0]   x;
    logic [ShiftWidth-1:0] amtBits;
    int                    lvl;
    nxtData = '0;
    for (int k = 0; k < PipeDepth; k++) begin
      x = stData[k];
      for (int i = 0; i < StagesPerReg; i++) begin
        lvl     = k * StagesPerReg + i;
        amtBits = stAmt[k] >> lvl;
        if (lvl < ShiftWidth && stEn[k] && amtBits[0])
          x = shiftLevel(x, lvl, stLeft[k], stRot[k], stArith[k], stSign[k]);
      end
      nxtData[k] = x;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      vReg     <= '0;
      enReg    <= '0;
      leftReg  <= '0;
      rotReg   <= '0;
      arithReg <= '0;
      signReg  <= '0;
      dataReg  <= '0;
      amtReg   <= '0;
    end else begin
      for (int k = 0; k < PipeDepth; k++) begin
        if (ld[k]) begin
          vReg[k] <= stValid[k];
          if (stValid[k]) begin
            dataReg[k]  <= nxtData[k];
            enReg[k]    <= stEn[k];
            leftReg[k]  <= stLeft[k];
            rotReg[k]   <= stRot[k];
            arithReg[k] <= stArith[k];
            signReg[k]  <= stSign[k];
            amtReg[k]   <= stAmt[k];
          end
        end
      end
    end
  end

  assign InReady  = ld[0];
  assign OutValid = vReg[PipeDepth-1];
  assign dOUT     = dataReg[PipeDepth-1];
  assign Busy     = |vReg;

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb/tb_pipelined_shifter.sv - directed-vector bench for pipelined_shifter
// BitWidth=8, StagesPerReg=1, so three register stages.
module tb_pipelined_shifter;

  logic       Clk, Rst, InValid, InReady, En, Left, RotateEnable, Arith;
  logic [7:0] dIN, dOUT;
  logic [2:0] ShAmount;
  logic       OutValid, OutReady, Busy;

  int nTests = 0;
  int nFail  = 0;
  int accepts, nextIdx, seen;

  pipelined_shifter #(.BitWidth(8), .StagesPerReg(1)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady), .En(En), .Left(Left),
    .RotateEnable(RotateEnable), .Arith(Arith), .dIN(dIN), .ShAmount(ShAmount),
    .OutValid(OutValid), .OutReady(OutReady), .dOUT(dOUT), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic setBeat(input logic en, input logic left, input logic rot, input logic arith,
                         input logic [7:0] d, input logic [2:0] amt);
    InValid = 1'b1; En = en; Left = left; RotateEnable = rot; Arith = arith;
    dIN = d; ShAmount = amt;
    #1;
  endtask

  initial begin
    Rst = 1'b1; InValid = 0; En = 0; Left = 0; RotateEnable = 0; Arith = 0;
    dIN = 0; ShAmount = 0; OutReady = 1'b1;
    step(); step();
    Rst = 1'b0;
    #1;
    checkVal("rst_outvalid", OutValid, 0);
    checkVal("rst_dout", dOUT, 0);
    checkVal("rst_busy", Busy, 0);
    checkVal("rst_inready", InReady, 1);

    // rotate left, latency 3
    setBeat(1, 1, 1, 0, 8'h16, 3'd2);
    checkVal("rotl_inready", InReady, 1);
    step();
    InValid = 0;
    checkVal("rotl_lat1", OutValid, 0);
    step();
    checkVal("rotl_lat2", OutValid, 0);
    step();
    checkVal("rotl_valid", OutValid, 1);
    checkVal("rotl_data", dOUT, 8'h58);
    step();
    checkVal("rotl_drain", OutValid, 0);

    // right modes back to back
    setBeat(1, 0, 0, 1, 8'h96, 3'd3); step();
    setBeat(1, 0, 0, 0, 8'h96, 3'd3); step();
    setBeat(1, 0, 1, 0, 8'h96, 3'd3); step();
    InValid = 0;
    checkVal("asr_valid", OutValid, 1);
    checkVal("asr_data", dOUT, 8'hF2);
    step();
    checkVal("lsr_valid", OutValid, 1);
    checkVal("lsr_data", dOUT, 8'h12);
    step();
    checkVal("rotr_valid", OutValid, 1);
    checkVal("rotr_data", dOUT, 8'hD2);
    step();
    checkVal("right_drain", OutValid, 0);

    // passthrough with En=0, then zero-distance arithmetic shift
    setBeat(0, 1, 0, 0, 8'hA5, 3'd7); step();
    setBeat(1, 0, 0, 1, 8'h80, 3'd0); step();
    InValid = 0;
    step();
    checkVal("pass_valid", OutValid, 1);
    checkVal("pass_data", dOUT, 8'hA5);
    step();
    checkVal("zero_valid", OutValid, 1);
    checkVal("zero_data", dOUT, 8'h80);
    step();

    // backpressure: five beats, only three fit
    OutReady = 1'b0;
    accepts  = 0;
    nextIdx  = 1;
    for (int c = 0; c < 5; c++) begin
      setBeat(1, 1, 0, 0, 8'(nextIdx), 3'd1);
      if (InReady) begin
        accepts++;
        nextIdx++;
      end
      step();
    end
    #1;
    checkVal("bp_accepts", accepts, 3);
    checkVal("bp_inready", InReady, 0);
    checkVal("bp_valid", OutValid, 1);
    checkVal("bp_hold", dOUT, 8'h02);
    OutReady = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      InValid = (nextIdx <= 5);
      dIN     = 8'(nextIdx);
      #1;
      checkVal($sformatf("bp_out%0d_valid", n), OutValid, 1);
      checkVal($sformatf("bp_out%0d_data", n), dOUT, 8'(2 * n));
      if (InValid && InReady) nextIdx++;
      step();
    end
    InValid = 0;
    #1;
    checkVal("bp_all_in", nextIdx, 6);
    checkVal("bp_drain", OutValid, 0);

    // bubble collapse behind a stalled last stage
    OutReady = 1'b0;
    setBeat(1, 1, 0, 0, 8'h10, 3'd1); step();
    InValid = 0;
    step(); step();
    checkVal("bub_last_valid", OutValid, 1);
    checkVal("bub_last_data", dOUT, 8'h20);
    setBeat(1, 1, 0, 0, 8'h11, 3'd1);
    checkVal("bub_rdy1", InReady, 1);
    step();
    checkVal("bub_busy1", Busy, 1);
    setBeat(1, 1, 0, 0, 8'h12, 3'd1);
    checkVal("bub_rdy2", InReady, 1);
    step();
    checkVal("bub_busy2", Busy, 1);
    InValid = 0;
    #1;
    checkVal("bub_full", InReady, 0);
    checkVal("bub_hold", dOUT, 8'h20);

    // reset with three beats in flight
    Rst = 1'b1;
    step();
    checkVal("mrst_valid", OutValid, 0);
    checkVal("mrst_dout", dOUT, 0);
    checkVal("mrst_busy", Busy, 0);
    checkVal("mrst_inready", InReady, 1);
    Rst      = 1'b0;
    OutReady = 1'b1;
    seen     = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (OutValid) seen++;
    end
    checkVal("mrst_no_stale", seen, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
